// File: rtl/l1_pkg.sv
// Shared L1 cache definitions: writeback/refill FSM states and AXI burst helpers.
package l1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wb_state_t;

    localparam int L1_OFFSET_WIDTH = 2;
    localparam int WORDS           = 1 << L1_OFFSET_WIDTH;
    localparam int AXI_LEN_WIDTH   = 8;

    // AXI encodes a burst of N beats as N-1.
    function automatic logic [AXI_LEN_WIDTH-1:0] burst_len(input int words);
        return AXI_LEN_WIDTH'(words - 1);
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO that decouples bram read latency from memory write-channel stalls.
module wb_skid_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    // NOTE: storage is deliberately left unreset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/l1_writeback.sv
// L1 dirty-line writeback: reads a line from the data bram and writes it out
// as one AXI-style burst (address phase, WORDS beats, write response).
module l1_writeback
    import l1_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int OFFSET_WIDTH = 2,
    parameter int INDEX_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_req,
    input  logic [INDEX_WIDTH-1:0] wb_index,
    input  logic [31:0]            wb_paddr,
    output logic                   wb_busy,
    output logic                   wb_done,
    output logic [ADDR_WIDTH-1:0]  bram_raddr,
    input  logic [DATA_WIDTH-1:0]  bram_dout,
    output logic                   mem_awvalid,
    input  logic                   mem_awready,
    output logic [31:0]            mem_awaddr,
    output logic [7:0]             mem_awlen,
    output logic                   mem_wvalid,
    input  logic                   mem_wready,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_wlast,
    input  logic                   mem_bvalid,
    output logic                   mem_bready
);

    localparam int                    LINE_WORDS = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH:0]   WORDS_CNT  = (OFFSET_WIDTH+1)'(LINE_WORDS);
    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT  = OFFSET_WIDTH'(LINE_WORDS - 1);
    localparam logic [31:0]             LINE_MASK  = ~32'((1 << (OFFSET_WIDTH + 2)) - 1);

    wb_state_t               state;
    logic [INDEX_WIDTH-1:0]  index_q;
    logic [OFFSET_WIDTH-1:0] offset_q;
    logic [OFFSET_WIDTH-1:0] beat_q;
    logic [OFFSET_WIDTH:0]   issued_q;
    logic                    inflight_q;

    logic [1:0]              fifo_count;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic                    accept;
    logic                    pop;
    logic                    issue;
    logic [2:0]              occ;

    assign accept     = (state == IDLE) && wb_req;
    assign mem_wvalid = (state == DATA) && (fifo_count != 2'd0);
    assign pop        = mem_wvalid && mem_wready;
    assign mem_wlast  = mem_wvalid && (beat_q == LAST_BEAT);
    assign mem_wdata  = mem_wvalid ? fifo_head : '0;

    // Occupancy after this cycle's pop, counting the word still in flight from the bram.
    assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = ((state == ADDR) || (state == DATA)) && (issued_q < WORDS_CNT) && (occ < 3'd2);

    assign bram_raddr = {index_q, offset_q};

    wb_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .pop  (pop),
        .din  (bram_dout),
        .dout (fifo_head),
        .count(fifo_count)
    );

    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            index_q     <= '0;
            wb_busy     <= 1'b0;
            wb_done     <= 1'b0;
            mem_awvalid <= 1'b0;
            mem_awaddr  <= '0;
            mem_awlen   <= '0;
            mem_bready  <= 1'b0;
        end else begin
            wb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_req) begin
                        index_q     <= wb_index;
                        mem_awaddr  <= wb_paddr & LINE_MASK;
                        mem_awlen   <= burst_len(LINE_WORDS);
                        mem_awvalid <= 1'b1;
                        wb_busy     <= 1'b1;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (mem_awready) begin
                        mem_awvalid <= 1'b0;
                        mem_awlen   <= '0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (pop && mem_wlast) begin
                        mem_bready <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (mem_bvalid) begin
                        mem_bready <= 1'b0;
                        wb_busy    <= 1'b0;
                        wb_done    <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Offset wraps within the line; it never carries into the latched index.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            offset_q   <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                offset_q <= offset_q + OFFSET_WIDTH'(1);
                issued_q <= issued_q + (OFFSET_WIDTH+1)'(1);
            end
            if (pop) begin
                beat_q <= beat_q + OFFSET_WIDTH'(1);
            end
        end
    end

endmodule
